lsp_resp: RTL

Final stage of the load-store pipe. Accepts completed memory operations from the LSP M1 stage and captures the data-memory load response. Extracts and sign/zero-extends the addressed load field. Delivers results in program order through a 2-entry output queue to the writeback stage's `lsp_wb_*` port using a valid/ready handshake.

---
 rtl/lsp_resp_pkg.sv | 33 +++
 rtl/lsp_ldext.sv | 32 +++
 rtl/lsp_resp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsp_resp_pkg.sv
// Shared types for the load-store pipe response stage: load size encodings,
// FSM states, the writeback queue entry and the outstanding-load hold record.
package lsp_resp_pkg;

   typedef enum logic [1:0] {
      LS_SIZE_B = 2'd0,
      LS_SIZE_H = 2'd1,
      LS_SIZE_W = 2'd2,
      LS_SIZE_D = 2'd3
   } ls_size_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_RESP = 1'b1
   } lsp_state_e;

   typedef struct packed {
      logic [4:0]  dst;
      logic [63:0] pc;
      logic        wb_en;
      logic [63:0] result;
   } wb_entry_t;

   typedef struct packed {
      logic [4:0]  dst;
      logic [63:0] pc;
      logic        wb_en;
      ls_size_e    size;
      logic        uns;
      logic [2:0]  addr_lo;
   } ld_hold_t;

endpackage

// File: rtl/lsp_ldext.sv
// Load field extractor: picks the addressed B/H/W/D field out of an aligned
// doubleword and sign- or zero-extends it to 64 bits.
module lsp_ldext
   import lsp_resp_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  ls_size_e    i_size,
   input  logic        i_unsigned,
   input  logic [2:0]  i_addr_lo,
   output logic [63:0] o_ext
);

   logic [7:0]  w_b;
   logic [15:0] w_h;
   logic [31:0] w_w;

   // Low address bits below the access size are dropped by the slice bases.
   assign w_b = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_h = i_rdata[{i_addr_lo[2:1], 4'b0000} +: 16];
   assign w_w = i_rdata[{i_addr_lo[2], 5'b00000} +: 32];

   always_comb begin
      o_ext = i_rdata;
      case (i_size)
         LS_SIZE_B: o_ext = {{56{~i_unsigned & w_b[7]}}, w_b};
         LS_SIZE_H: o_ext = {{48{~i_unsigned & w_h[15]}}, w_h};
         LS_SIZE_W: o_ext = {{32{~i_unsigned & w_w[31]}}, w_w};
         default:   o_ext = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsp_resp.sv
// Load-store pipe final stage: holds one outstanding load, extends its data,
// and returns results in program order through a 2-entry writeback queue.
module lsp_resp
   import lsp_resp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [4:0]  m1_dst,
   input  logic [63:0] m1_pc,
   input  logic        m1_wb_en,
   input  logic        m1_is_load,
   input  logic [1:0]  m1_size,
   input  logic        m1_unsigned,
   input  logic [2:0]  m1_addr_lo,
   input  logic [63:0] m1_result,
   input  logic        dm_resp_valid,
   input  logic [63:0] dm_resp_rdata,
   output logic        lsp_wb_valid,
   input  logic        lsp_wb_ready,
   output logic [4:0]  lsp_wb_dst,
   output logic [63:0] lsp_wb_pc,
   output logic        lsp_wb_wb_en,
   output logic [63:0] lsp_wb_result
);

   lsp_state_e r_state, w_state_nxt;
   ld_hold_t   r_hold;
   wb_entry_t  r_q [DEPTH];
   logic       r_wr_ptr, r_rd_ptr;
   logic [1:0] r_count;

   logic       w_accept, w_enq, w_deq, w_hold_ld;
   wb_entry_t  w_enq_data, w_head;
   logic [63:0] w_ld_data;

   // rst gates ready so M1 sees no acceptance while reset is held.
   assign m1_ready = (r_state == ST_IDLE) && (r_count < 2'(DEPTH)) && rst;
   assign w_accept = m1_valid && m1_ready;
   assign w_deq    = lsp_wb_valid && lsp_wb_ready;

   lsp_ldext u_ldext (
      .i_rdata    (dm_resp_rdata),
      .i_size     (r_hold.size),
      .i_unsigned (r_hold.uns),
      .i_addr_lo  (r_hold.addr_lo),
      .o_ext      (w_ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enq       = 1'b0;
      w_hold_ld   = 1'b0;
      w_enq_data  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (m1_is_load) begin
                  w_hold_ld   = 1'b1;
                  w_state_nxt = ST_WAIT_RESP;
               end else begin
                  w_enq             = 1'b1;
                  w_enq_data.dst    = m1_dst;
                  w_enq_data.pc     = m1_pc;
                  w_enq_data.wb_en  = m1_wb_en;
                  w_enq_data.result = m1_result;
               end
            end
         end
         ST_WAIT_RESP: begin
            // A free slot is guaranteed: count < DEPTH at accept and only falls since.
            if (dm_resp_valid) begin
               w_enq             = 1'b1;
               w_enq_data.dst    = r_hold.dst;
               w_enq_data.pc     = r_hold.pc;
               w_enq_data.wb_en  = r_hold.wb_en;
               w_enq_data.result = w_ld_data;
               w_state_nxt       = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold <= '0;
      end else if (w_hold_ld) begin
         r_hold.dst     <= m1_dst;
         r_hold.pc      <= m1_pc;
         r_hold.wb_en   <= m1_wb_en;
         r_hold.size    <= ls_size_e'(m1_size);
         r_hold.uns     <= m1_unsigned;
         r_hold.addr_lo <= m1_addr_lo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_enq) begin
            r_q[r_wr_ptr] <= w_enq_data;
            r_wr_ptr      <= ~r_wr_ptr;
         end
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head        = r_q[r_rd_ptr];
   assign lsp_wb_valid  = (r_count != 2'd0);
   assign lsp_wb_dst    = w_head.dst;
   assign lsp_wb_pc     = w_head.pc;
   assign lsp_wb_wb_en  = w_head.wb_en;
   assign lsp_wb_result = w_head.result;

endmodule
